// File: rtl/serv_dbus_nibif.sv
// Nibble-serial data-bus interface: collects store data, runs one registered bus cycle, and
// streams aligned/extended load data back. Optional macro: SERV_DBUS_MISALIGN_EN.
module serv_dbus_nibif #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int LB             = $clog2(BITS_PER_CYCLE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_cnt0,
  input  logic                      i_mem_op,
  input  logic                      i_mem_cmd,
  input  logic                      i_word,
  input  logic                      i_half,
  input  logic                      i_signed,
  input  logic [1:0]                i_lsb,
  input  logic [31:0]               i_adr,
  input  logic [BITS_PER_CYCLE-1:0] i_rs2,
  output logic [BITS_PER_CYCLE-1:0] o_rd,
  output logic                      o_busy,
  output logic                      o_misalign,
  output logic [31:0]               o_dbus_adr,
  output logic [31:0]               o_dbus_dat,
  output logic [3:0]                o_dbus_sel,
  output logic                      o_dbus_we,
  output logic                      o_dbus_cyc,
  input  logic [31:0]               i_dbus_rdt,
  input  logic                      i_dbus_ack
);

  localparam int CW = 5 - LB;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REQ     = 2'd2,
    S_RDOUT   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [31:0]     dreg_r, dreg_s;
  logic            cyc_r, we_r, busy_r, mis_r, mis_s;
  logic [3:0]      sel_r, sel_s;
  logic [31:0]     adr_r, dat_r, dat_s, ld_s;
  logic            last_s, ack_s, launch_s, misaligned_s;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic word,
                                           input logic half, input logic sgn);
    logic [31:0] r;
    if (word)
      r = w;
    else if (half)
      r = {{16{sgn & w[15]}}, w[15:0]};
    else
      r = {{24{sgn & w[7]}}, w[7:0]};
    return r;
  endfunction

  assign last_s = &cnt_r;
  // An ack is only meaningful while the request is actually on the bus
  assign ack_s  = cyc_r & i_dbus_ack;
  assign ld_s   = load_ext(i_dbus_rdt >> {i_lsb, 3'b000}, i_word, i_half, i_signed);

`ifdef SERV_DBUS_MISALIGN_EN
  assign misaligned_s = (i_half & ~i_word & i_lsb[0]) | (i_word & (i_lsb != 2'b00));
`else
  assign misaligned_s = 1'b0;
`endif

  // Write data replication and byte enables for the access size
  always_comb begin
    dat_s = dreg_r;
    sel_s = 4'b1111;
    if (i_word) begin
      dat_s = dreg_r;
      sel_s = 4'b1111;
    end else if (i_half) begin
      dat_s = {2{dreg_r[15:0]}};
      sel_s = i_lsb[1] ? 4'b1100 : 4'b0011;
    end else begin
      dat_s = {4{dreg_r[7:0]}};
      sel_s = 4'b0001 << i_lsb;
    end
  end

  // Next-state, data register and counter update
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    dreg_s   = dreg_r;
    mis_s    = 1'b0;
    launch_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_en & i_cnt0 & i_mem_op) begin
          state_s = S_COLLECT;
          dreg_s  = {i_rs2, dreg_r[31:BITS_PER_CYCLE]};
          cnt_s   = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (i_en) begin
          dreg_s = {i_rs2, dreg_r[31:BITS_PER_CYCLE]};
          cnt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            if (misaligned_s) begin
              state_s = S_IDLE;
              mis_s   = 1'b1;
            end else begin
              state_s = S_REQ;
            end
          end else begin
            state_s = S_COLLECT;
          end
        end else begin
          state_s = S_COLLECT;
        end
      end
      S_REQ: begin
        // First REQ cycle has cyc low: that is when the bus outputs get loaded
        launch_s = ~cyc_r;
        if (ack_s) begin
          if (we_r) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_RDOUT;
            dreg_s  = ld_s;
          end
        end else begin
          state_s = S_REQ;
        end
      end
      S_RDOUT: begin
        if (i_en) begin
          dreg_s = {{BITS_PER_CYCLE{1'b0}}, dreg_r[31:BITS_PER_CYCLE]};
          cnt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          state_s = last_s ? S_IDLE : S_RDOUT;
        end else begin
          state_s = S_RDOUT;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // FSM, data register and status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      dreg_r  <= 32'h0000_0000;
      busy_r  <= 1'b0;
      mis_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dreg_r  <= dreg_s;
      busy_r  <= (state_s == S_REQ);
      mis_r   <= mis_s;
    end
  end

  // Bus outputs: loaded at launch, held until ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_r <= 1'b0;
      we_r  <= 1'b0;
      sel_r <= 4'b0000;
      adr_r <= 32'h0000_0000;
      dat_r <= 32'h0000_0000;
    end else if (launch_s) begin
      cyc_r <= 1'b1;
      we_r  <= i_mem_cmd;
      sel_r <= sel_s;
      adr_r <= i_adr;
      dat_r <= dat_s;
    end else if (ack_s) begin
      cyc_r <= 1'b0;
      we_r  <= 1'b0;
      sel_r <= 4'b0000;
    end
  end

  // Read data is handed to rd in the same cycle the core steps
  assign o_rd       = ((state_r == S_RDOUT) && i_en) ? dreg_r[BITS_PER_CYCLE-1:0]
                                                     : {BITS_PER_CYCLE{1'b0}};
  assign o_busy     = busy_r;
  assign o_misalign = mis_r;
  assign o_dbus_adr = adr_r;
  assign o_dbus_dat = dat_r;
  assign o_dbus_sel = sel_r;
  assign o_dbus_we  = we_r;
  assign o_dbus_cyc = cyc_r;

endmodule

// File: tb/tb_serv_dbus_nibif.sv
// Bench for serv_dbus_nibif: fixed vector table, hand-written corner sequences, and
// randomized transactions checked against an arithmetic reference model.
module tb_serv_dbus_nibif;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, cnt0, mem_op, mem_cmd, word, half, sgn;
  logic [1:0]  lsb;
  logic [31:0] adr, dbus_rdt, dbus_adr, dbus_dat;
  logic [3:0]  rs2, rd, dbus_sel;
  logic        busy, misalign, dbus_we, dbus_cyc, dbus_ack;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        cmd;
    logic        word;
    logic        half;
    logic        sgn;
    logic [1:0]  lsb;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdt;
    int          stalls;
    logic [31:0] exp_dat;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  serv_dbus_nibif dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cnt0(cnt0), .i_mem_op(mem_op),
    .i_mem_cmd(mem_cmd), .i_word(word), .i_half(half), .i_signed(sgn), .i_lsb(lsb),
    .i_adr(adr), .i_rs2(rs2), .o_rd(rd), .o_busy(busy), .o_misalign(misalign),
    .o_dbus_adr(dbus_adr), .o_dbus_dat(dbus_dat), .o_dbus_sel(dbus_sel),
    .o_dbus_we(dbus_we), .o_dbus_cyc(dbus_cyc), .i_dbus_rdt(dbus_rdt), .i_dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: sizes and offsets worked out directly from the access rules
  function automatic vec_t model(input vec_t v);
    int nb, st;
    logic [31:0] sh;
    nb = v.word ? 4 : (v.half ? 2 : 1);
    st = v.word ? 0 : (v.half ? int'(v.lsb & 2'b10) : int'(v.lsb));
    v.exp_sel = 4'(((1 << nb) - 1) << st);
    if (v.word)      v.exp_dat = v.wdata;
    else if (v.half) v.exp_dat = v.wdata[15:0] * 32'h0001_0001;
    else             v.exp_dat = v.wdata[7:0] * 32'h0101_0101;
    sh = v.rdt >> (8 * v.lsb);
    if (v.word) begin
      v.exp_rd = sh;
    end else if (v.half) begin
      v.exp_rd = {16'h0000, sh[15:0]};
      if (v.sgn && sh[15]) v.exp_rd = v.exp_rd - 32'h0001_0000;
    end else begin
      v.exp_rd = {24'h000000, sh[7:0]};
      if (v.sgn && sh[7]) v.exp_rd = v.exp_rd - 32'h0000_0100;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    en = 1'b0; cnt0 = 1'b0; mem_op = 1'b0; mem_cmd = 1'b0; word = 1'b0; half = 1'b0;
    sgn = 1'b0; lsb = 2'd0; adr = 32'h0; rs2 = 4'h0; dbus_rdt = 32'h0; dbus_ack = 1'b0;
  endtask

  // Serially present the 8 rs2 nibbles starting with the cnt0 step
  task automatic feed(input vec_t v);
    mem_op = 1'b1; mem_cmd = v.cmd; word = v.word; half = v.half; sgn = v.sgn;
    lsb = v.lsb; adr = v.adr;
    for (int k = 0; k < 8; k++) begin
      en = 1'b1; cnt0 = (k == 0); rs2 = v.wdata[4*k +: 4];
      @(negedge clk);
    end
    en = 1'b0; cnt0 = 1'b0;
  endtask

  task automatic run_txn(input string nm, input vec_t v);
    logic got;
    logic [31:0] rdv;
    feed(v);
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      if (dbus_cyc) got = 1'b1;
      else @(negedge clk);
    end
    chk({nm, " cyc_launch"}, got, 1'b1);
    if (!got) begin
      idle_inputs();
      return;
    end
    chk({nm, " bus"}, {busy, dbus_we, dbus_sel, dbus_adr}, {1'b1, v.cmd, v.exp_sel, v.adr});
    if (v.cmd) chk({nm, " dat"}, dbus_dat, v.exp_dat);
    for (int s = 0; s < v.stalls; s++) begin
      @(negedge clk);
      chk({nm, " hold"}, {dbus_cyc, busy, dbus_sel, dbus_adr}, {2'b11, v.exp_sel, v.adr});
      if (v.cmd) chk({nm, " hold_dat"}, dbus_dat, v.exp_dat);
    end
    dbus_rdt = v.rdt; dbus_ack = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b0; dbus_rdt = $urandom;
    chk({nm, " after_ack"}, {dbus_cyc, busy, misalign, rd}, 7'b0);
    if (!v.cmd) begin
      rdv = 32'h0;
      for (int n = 0; n < 8; n++) begin
        en = 1'b1;
        #1 rdv[4*n +: 4] = rd;
        @(negedge clk);
      end
      en = 1'b0;
      chk({nm, " rd"}, rdv, v.exp_rd);
    end
    mem_op = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl[8];
  vec_t v;
  int   mis_cnt, cyc_seen, sz;

  initial begin
    //          cmd   word  half  sgn   lsb   adr           wdata         rdt           st exp_dat       sel      exp_rd
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0010, 32'h0000_00A5, 32'h0,        3, 32'hA5A5_A5A5, 4'b0100, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h2000_0004, 32'h0,        32'h80F0_1234, 1, 32'h0,        4'b1100, 32'hFFFF_80F0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0000_0100, 32'h0,        32'h9A00_0000, 0, 32'h0,        4'b1000, 32'h0000_009A};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFFC, 32'h0,        32'hDEAD_BEEF, 20, 32'h0,       4'b1111, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0008, 32'h1234_5678, 32'h0,        2, 32'h1234_5678, 4'b1111, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_000C, 32'hCAFE_BEEF, 32'h0,        0, 32'hBEEF_BEEF, 4'b0011, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0020, 32'h0,        32'h0000_8000, 1, 32'h0,        4'b0010, 32'hFFFF_FF80};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0024, 32'h0,        32'h1234_F00D, 0, 32'h0,        4'b0011, 32'h0000_F00D};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {dbus_cyc, dbus_we, busy, misalign, dbus_sel, rd}, 12'h000);
    chk("reset_bus", {dbus_adr, dbus_dat}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Spurious ack while nothing is on the bus
    dbus_ack = 1'b1; dbus_rdt = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    dbus_ack = 1'b0;
    chk("spurious_ack", {dbus_cyc, busy, rd}, 6'h00);
    run_txn("post_spurious", tbl[3]);

    // Asynchronous reset while the request is outstanding
    feed(tbl[1]);
    for (int t = 0; t < 8 && !dbus_cyc; t++) @(negedge clk);
    chk("rst_pre_cyc", dbus_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {dbus_cyc, busy}, 2'b00);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    run_txn("post_reset_lw", tbl[3]);

    // Word access at byte offset 1
    v = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0040, 32'h0, 32'h1122_3344, 1, 32'h0, 4'h0, 32'h0};
`ifdef SERV_DBUS_MISALIGN_EN
    feed(v);
    mis_cnt = 0; cyc_seen = 0;
    for (int t = 0; t < 12; t++) begin
      mis_cnt += int'(misalign);
      cyc_seen += int'(dbus_cyc);
      @(negedge clk);
    end
    chk("misalign_pulses", mis_cnt, 1);
    chk("misalign_no_cyc", {cyc_seen, busy}, {32'd0, 1'b0});
    idle_inputs();
    @(negedge clk);
`else
    v = model(v);
    run_txn("lw_lsb1", v);
`endif

    for (int i = 0; i < 30; i++) begin
      v.cmd  = 1'($urandom_range(0, 1));
      sz     = $urandom_range(0, 2);
      v.word = (sz == 2);
      v.half = (sz == 1);
      v.sgn  = 1'($urandom_range(0, 1));
      v.lsb  = 2'($urandom_range(0, 3));
`ifdef SERV_DBUS_MISALIGN_EN
      if (v.word) v.lsb = 2'd0;
      if (v.half) v.lsb = v.lsb & 2'b10;
`endif
      v.adr    = $urandom & 32'hFFFF_FFFC;
      v.wdata  = $urandom;
      v.rdt    = $urandom;
      v.stalls = $urandom_range(0, 4);
      v = model(v);
      run_txn($sformatf("rnd%0d", i), v);
      chk("rnd_misalign_low", misalign, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
